// File: rtl/fetch_queue_pkg.sv
// Shared constants, entry layout and helpers for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] PC_BASE   = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;
    localparam int FQ_DEPTH   = 4;
    localparam int ENTRY_W    = 2 * WORD_WIDTH;

    // One queued fetch: pc in the upper word, instruction in the lower word.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } fq_entry_t;

    function automatic fq_entry_t fq_pack(input logic [WORD_WIDTH-1:0] pc,
                                          input logic [WORD_WIDTH-1:0] instr);
        fq_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry storage: register array with one synchronous write
// port and one combinational read port. Contents are never reset.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [ENTRY_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [ENTRY_W-1:0]         rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Capture the written entry; stale data is harmless because reads are
    // qualified by the occupancy count in the parent.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Head entry read without a register so decode sees it in the same cycle.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of (pc, instr) pairs between fetch
// and decode, with valid/ready on both sides and a single-cycle flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WORD_WIDTH-1:0]      in_pc,
    input  logic [WORD_WIDTH-1:0]      in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WORD_WIDTH-1:0]      out_pc,
    output logic [WORD_WIDTH-1:0]      out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             push;
    logic             pop;
    fq_entry_t        wr_entry;
    fq_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_raw;

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head_raw)
    );

    // Handshake decode: both ready and valid come from registered occupancy
    // only, so fetch stall never depends combinationally on decode stall.
    always_comb begin
        in_ready  = (count_q != CNT_FULL);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        wr_entry  = fq_pack(in_pc, in_instr);
    end

    // Next pointer/count state; flush wins over any concurrent push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head presentation: an empty queue shows a NOP at the base PC rather
    // than whatever stale entry the read pointer happens to address.
    always_comb begin
        head_entry = fq_entry_t'(head_raw);
        count      = count_q;
        if (out_valid) begin
            out_pc    = head_entry.pc;
            out_instr = head_entry.instr;
        end else begin
            out_pc    = PC_BASE;
            out_instr = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for the fetch queue plus hand-written
// sequences for reset, simultaneous push/pop and the first push after reset.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int NVEC  = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Inputs applied during a cycle, and the outputs expected in that same
    // cycle (before the edge that consumes the inputs).
    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return 32'h0013_0000 ^ pc ^ 32'h8000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [2:0] e_cnt, input logic e_rdy,
                               input logic e_vld, input logic [31:0] e_pc);
        logic [31:0] e_instr;
        e_instr = e_vld ? mk_instr(e_pc) : NOP_INSTR;
        chk({tag, ".count"},     32'(count),     32'(e_cnt));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
        chk({tag, ".out_pc"},    out_pc,         e_pc);
        chk({tag, ".out_instr"}, out_instr,      e_instr);
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        flush     = fl;
        out_ready = ordy;
    endtask

    initial begin
        // fill/drain, 5th push ignored
        tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};
        tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h00};
        tbl[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 32'h00};
        tbl[5]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h00};
        tbl[6]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h04};
        tbl[7]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h08};
        tbl[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h0C};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};
        // full plus pop: only the pop happens, push lands next cycle
        tbl[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};
        tbl[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h20};
        tbl[12] = '{1'b1, 32'h28, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h20};
        tbl[13] = '{1'b1, 32'h2C, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h20};
        tbl[14] = '{1'b1, 32'h30, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h20};
        tbl[15] = '{1'b1, 32'h30, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h24};
        tbl[16] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h24};
        tbl[17] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h28};
        tbl[18] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h2C};
        tbl[19] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h30};
        // flush with concurrent push and pop, then recovery
        tbl[20] = '{1'b1, 32'h60, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};
        tbl[21] = '{1'b1, 32'h64, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h60};
        tbl[22] = '{1'b1, 32'h68, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h60};
        tbl[23] = '{1'b1, 32'h100, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 32'h60};
        tbl[24] = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};
        tbl[25] = '{1'b1, 32'h200, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};
        tbl[26] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h200};
        // back-to-back through an empty queue
        tbl[27] = '{1'b1, 32'h40, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, PC_BASE};
        tbl[28] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h40};
        tbl[29] = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, PC_BASE};

        // Power-on reset
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk_outputs("por", 3'd0, 1'b1, 1'b0, PC_BASE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].iv, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
            #1;
            chk_outputs($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_rdy,
                        tbl[i].e_vld, tbl[i].e_pc);
        end

        // Simultaneous push/pop with two entries queued, across several wraps
        @(negedge clk); drive(1'b1, 32'h300, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 32'h304, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h308 + 32'(4 * k), 1'b0, 1'b1);
            #1;
            chk($sformatf("pp%0d.count", k),  32'(count), 32'd2);
            chk($sformatf("pp%0d.out_pc", k), out_pc, 32'h300 + 32'(4 * k));
            chk($sformatf("pp%0d.out_instr", k), out_instr, mk_instr(32'h300 + 32'(4 * k)));
        end

        // Asynchronous reset mid-cycle with two entries queued
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst.count", 32'(count), 32'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_outputs("mid_rst", 3'd0, 1'b1, 1'b0, PC_BASE);

        // First push after deassertion is taken on the first edge with rst low
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk_outputs("post_rst", 3'd1, 1'b1, 1'b1, 32'h500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
